// File: rtl/exec_pkg.sv
// exec_pkg: shared types and constants for the execute stage.
//   op_e       - 4-bit opcode encoding (12..15 undefined)
//   state_e    - execute_unit FSM states
//   DATA_W / REG_ADDR_W - default datapath and register address widths
//   DIV0_QUOT  - quotient returned by DIVU when the divisor is zero
package exec_pkg;

  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 6;

  localparam logic [DATA_W-1:0] DIV0_QUOT = '1;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_SLL  = 4'd5,
    OP_SRL  = 4'd6,
    OP_SRA  = 4'd7,
    OP_SLT  = 4'd8,
    OP_MUL  = 4'd9,
    OP_DIVU = 4'd10,
    OP_REMU = 4'd11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/muldiv_iter.sv
// muldiv_iter: iterative 32-step multiplier / restoring divider.
// Only built when EXEC_MULDIV_EN is defined.
//   clk, reset   - clock, asynchronous active-high reset
//   i_start      - latch operands/op, clear the step counter
//   i_step       - perform one iteration this cycle
//   i_op         - OP_MUL, OP_DIVU or OP_REMU
//   i_a, i_b     - operands (dividend/divisor for divide)
//   o_last       - the step performed this cycle is the final (32nd) one
//   o_result     - final result, valid once the last step has been taken
module muldiv_iter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_start,
  input  logic         i_step,
  input  logic [3:0]   i_op,
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic         o_last,
  output logic [W-1:0] o_result
);
  import exec_pkg::*;

  // r_acc: product accumulator (MUL) or partial remainder (DIV)
  // r_x:   multiplier shifting right (MUL) or dividend->quotient (DIV)
  // r_y:   multiplicand shifting left (MUL) or fixed divisor (DIV)
  logic [W-1:0] r_acc;
  logic [W-1:0] r_x;
  logic [W-1:0] r_y;
  logic [4:0]   r_count;
  logic         r_is_mul;
  logic         r_is_rem;
  logic         r_div0;

  // Restoring step: shift next dividend bit into the remainder and try to
  // subtract. Bit W of the difference is the borrow.
  logic [W:0] w_shift;
  logic [W:0] w_diff;
  logic       w_ge;

  assign w_shift = {r_acc, r_x[W-1]};
  assign w_diff  = w_shift - {1'b0, r_y};
  assign w_ge    = ~w_diff[W];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc    <= '0;
      r_x      <= '0;
      r_y      <= '0;
      r_count  <= '0;
      r_is_mul <= 1'b0;
      r_is_rem <= 1'b0;
      r_div0   <= 1'b0;
    end else if (i_start) begin
      r_acc    <= '0;
      r_x      <= i_a;
      r_y      <= i_b;
      r_count  <= '0;
      r_is_mul <= (i_op == OP_MUL);
      r_is_rem <= (i_op == OP_REMU);
      r_div0   <= (i_b == '0);
    end else if (i_step) begin
      r_count <= r_count + 5'd1;
      if (r_is_mul) begin
        if (r_x[0]) r_acc <= r_acc + r_y;
        r_y <= r_y << 1;
        r_x <= r_x >> 1;
      end else begin
        r_acc <= w_ge ? w_diff[W-1:0] : w_shift[W-1:0];
        r_x   <= {r_x[W-2:0], w_ge};
      end
    end
  end

  assign o_last = (r_count == 5'd31);

  // A zero divisor leaves the dividend in r_acc, which is already the
  // required REMU answer; only the quotient needs overriding.
  assign o_result = (r_is_mul || r_is_rem) ? r_acc :
                    (r_div0 ? DIV0_QUOT : r_x);

endmodule

// File: rtl/execute_unit.sv
// execute_unit: single-issue execute stage driving the register file write port.
// Single-cycle ALU ops write back the cycle after acceptance; MUL/DIVU/REMU
// iterate for 32 cycles and write back 33 cycles after acceptance.
// Build option: EXEC_MULDIV_EN enables MUL/DIVU/REMU; when undefined those
// opcodes are illegal, RUN/DONE are unreachable and busy is tied low.
// Ports:
//   clk, reset          - clock, asynchronous active-high reset
//   in_valid/in_ready   - accept handshake from decode
//   in_op, in_a, in_b   - opcode and operands
//   in_dest             - destination register
//   wb_en/wb_addr/wb_data - register file write port (wb_en one-cycle pulse)
//   illegal_op          - one-cycle pulse on an undefined opcode
//   busy                - multi-cycle op in flight (RUN or DONE)
//   dbg_state           - current FSM state
//
// Handshake: an op is accepted on a rising edge where in_valid && in_ready.
// in_ready is high only in IDLE; in_valid while in_ready is low is ignored
// and decode holds its inputs until accepted.
module execute_unit #(
  parameter int DATA_W     = exec_pkg::DATA_W,
  parameter int REG_ADDR_W = exec_pkg::REG_ADDR_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            in_op,
  input  logic [DATA_W-1:0]     in_a,
  input  logic [DATA_W-1:0]     in_b,
  input  logic [REG_ADDR_W-1:0] in_dest,
  output logic                  wb_en,
  output logic [REG_ADDR_W-1:0] wb_addr,
  output logic [DATA_W-1:0]     wb_data,
  output logic                  illegal_op,
  output logic                  busy,
  output logic [1:0]            dbg_state
);
  import exec_pkg::*;

  state_e                r_state;
  logic                  r_in_ready;
  logic                  r_wb_en;
  logic [REG_ADDR_W-1:0] r_wb_addr;
  logic [DATA_W-1:0]     r_wb_data;
  logic                  r_illegal;

  state_e                w_state_next;
  logic                  w_wb_en_next;
  logic [REG_ADDR_W-1:0] w_wb_addr_next;
  logic [DATA_W-1:0]     w_wb_data_next;
  logic                  w_illegal_next;
  logic                  w_md_start;

  // Single-cycle ALU
  logic [DATA_W-1:0] w_alu;
  logic              w_alu_op;
  logic              w_md_op;

  always_comb begin
    w_alu    = '0;
    w_alu_op = 1'b1;
    w_md_op  = 1'b0;
    case (in_op)
      OP_ADD:  w_alu = in_a + in_b;
      OP_SUB:  w_alu = in_a - in_b;
      OP_AND:  w_alu = in_a & in_b;
      OP_OR:   w_alu = in_a | in_b;
      OP_XOR:  w_alu = in_a ^ in_b;
      OP_SLL:  w_alu = in_a << in_b[4:0];
      OP_SRL:  w_alu = in_a >> in_b[4:0];
      OP_SRA:  w_alu = $unsigned($signed(in_a) >>> in_b[4:0]);
      OP_SLT:  w_alu = {{(DATA_W-1){1'b0}}, ($signed(in_a) < $signed(in_b))};
      OP_MUL, OP_DIVU, OP_REMU: begin
        w_alu_op = 1'b0;
`ifdef EXEC_MULDIV_EN
        w_md_op  = 1'b1;
`endif
      end
      default: w_alu_op = 1'b0;
    endcase
  end

`ifdef EXEC_MULDIV_EN
  logic                  w_md_last;
  logic [DATA_W-1:0]     w_md_result;
  logic [REG_ADDR_W-1:0] r_dest;
  logic                  r_busy;

  muldiv_iter #(.W(DATA_W)) u_muldiv (
    .clk      (clk),
    .reset    (reset),
    .i_start  (w_md_start),
    .i_step   (r_state == RUN),
    .i_op     (in_op),
    .i_a      (in_a),
    .i_b      (in_b),
    .o_last   (w_md_last),
    .o_result (w_md_result)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_dest <= '0;
      r_busy <= 1'b0;
    end else begin
      if (w_md_start) r_dest <= in_dest;
      r_busy <= (w_state_next != IDLE);
    end
  end

  assign busy = r_busy;
`else
  assign busy = 1'b0;
`endif

  always_comb begin
    w_state_next   = r_state;
    w_wb_en_next   = 1'b0;
    w_wb_addr_next = r_wb_addr;
    w_wb_data_next = r_wb_data;
    w_illegal_next = 1'b0;
    w_md_start     = 1'b0;
    case (r_state)
      IDLE: begin
        if (in_valid) begin
          if (w_alu_op) begin
            w_wb_en_next   = 1'b1;
            w_wb_addr_next = in_dest;
            w_wb_data_next = w_alu;
          end else if (w_md_op) begin
            w_md_start   = 1'b1;
            w_state_next = RUN;
          end else begin
            w_illegal_next = 1'b1;
          end
        end
      end
`ifdef EXEC_MULDIV_EN
      RUN: begin
        if (w_md_last) w_state_next = DONE;
      end
      DONE: begin
        w_wb_en_next   = 1'b1;
        w_wb_addr_next = r_dest;
        w_wb_data_next = w_md_result;
        w_state_next   = IDLE;
      end
`endif
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_in_ready <= 1'b1;
      r_wb_en    <= 1'b0;
      r_wb_addr  <= '0;
      r_wb_data  <= '0;
      r_illegal  <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_in_ready <= (w_state_next == IDLE);
      r_wb_en    <= w_wb_en_next;
      r_wb_addr  <= w_wb_addr_next;
      r_wb_data  <= w_wb_data_next;
      r_illegal  <= w_illegal_next;
    end
  end

  assign in_ready   = r_in_ready;
  assign wb_en      = r_wb_en;
  assign wb_addr    = r_wb_addr;
  assign wb_data    = r_wb_data;
  assign illegal_op = r_illegal;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_execute_unit.sv
// Testbench for execute_unit: directed cases plus random ALU traffic;
// write-backs are checked against an expected queue.
module tb_execute_unit;
  import exec_pkg::*;

  localparam int DW = 32;
  localparam int AW = 6;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    in_op;
  logic [DW-1:0] in_a;
  logic [DW-1:0] in_b;
  logic [AW-1:0] in_dest;
  logic          wb_en;
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_data;
  logic          illegal_op;
  logic          busy;
  logic [1:0]    dbg_state;

  always #5 clk = ~clk;

  execute_unit #(.DATA_W(DW), .REG_ADDR_W(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_dest    (in_dest),
    .wb_en      (wb_en),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data),
    .illegal_op (illegal_op),
    .busy       (busy),
    .dbg_state  (dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [AW+DW-1:0] exp_q[$];
  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] model(input logic [3:0] op, input logic [DW-1:0] a,
                                           input logic [DW-1:0] b);
    case (op)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return a ^ b;
      4'd5:  return a << b[4:0];
      4'd6:  return a >> b[4:0];
      4'd7:  return $unsigned($signed(a) >>> b[4:0]);
      4'd8:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd9:  return a * b;
      4'd10: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      4'd11: return (b == 0) ? a : a % b;
      default: return '0;
    endcase
  endfunction

  // Compare every write-back against the head of the queue.
  always @(negedge clk) begin
    if (reset === 1'b0 && wb_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("wb_unexpected", wb_en, 1'b0);
      end else begin
        logic [AW+DW-1:0] e;
        e = exp_q.pop_front();
        check("wb", {wb_addr, wb_data}, e);
      end
    end
  end

  // ---------------- driver ----------------
  task automatic issue(input logic [3:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic [AW-1:0] d, input bit expect_wb);
    int n = 0;
    while (in_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("ready_timeout", in_ready, 1'b1);
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_dest  = d;
    if (expect_wb) exp_q.push_back({d, model(op, a, b)});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0; in_dest = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready",   in_ready,   1'b1);
    check("rst_wb_en",   wb_en,      1'b0);
    check("rst_wb_addr", wb_addr,    '0);
    check("rst_wb_data", wb_data,    '0);
    check("rst_illegal", illegal_op, 1'b0);
    check("rst_busy",    busy,       1'b0);
    @(negedge clk);
    reset = 1'b0;

    // ADD wraps to zero, one-cycle latency, no stall
    issue(OP_ADD, 32'hFFFF_FFFF, 32'd1, 6'd5, 1'b1);
    @(negedge clk);
    check("add_wb_en", wb_en, 1'b1);
    check("add_ready", in_ready, 1'b1);

    // back-to-back SRA then SLT
    issue(OP_SRA, 32'h8000_0000, 32'd4, 6'd6, 1'b1);
    issue(OP_SLT, 32'hFFFF_FFFF, 32'd1, 6'd7, 1'b1);
    @(negedge clk);
    check("b2b_wb_en", wb_en, 1'b1);

    // destination 0 written like any other register
    issue(OP_OR, 32'h1234_0000, 32'h0000_5678, 6'd0, 1'b1);

    // undefined opcode
    issue(4'd14, 32'd1, 32'd2, 6'd3, 1'b0);
    @(negedge clk);
    check("ill14_pulse", illegal_op, 1'b1);
    check("ill14_no_wb", wb_en, 1'b0);
    @(negedge clk);
    check("ill14_clear", illegal_op, 1'b0);

    // random single-cycle traffic, back-to-back
    for (int i = 0; i < 24; i++) begin
      issue(4'($urandom_range(0, 8)), $urandom, $urandom, 6'($urandom_range(0, 63)), 1'b1);
    end
    repeat (2) @(negedge clk);

`ifdef EXEC_MULDIV_EN
    begin
      int n = 0;
      issue(OP_MUL, 32'd123456, 32'd1000, 6'd9, 1'b1);
      @(negedge clk);
      check("mul_busy_run", busy, 1'b1);
      while (!in_ready && n < 100) begin
        n++;
        @(negedge clk);
      end
      check("mul_ready_low", n, 33);
      check("mul_wb_en", wb_en, 1'b1);
      check("mul_wb_data", wb_data, 32'h075B_CA00);
      check("mul_busy_done", busy, 1'b0);
    end

    issue(OP_DIVU, 32'd100, 32'd0, 6'd10, 1'b1);
    issue(OP_REMU, 32'd100, 32'd7, 6'd11, 1'b1);
    for (int i = 0; i < 6; i++) begin
      issue(4'($urandom_range(9, 11)), $urandom, 32'($urandom_range(0, 1000)),
            6'($urandom_range(0, 63)), 1'b1);
    end
    repeat (40) @(negedge clk);

    // reset in the middle of RUN: aborted op must never write back
    issue(OP_MUL, 32'd7, 32'd3, 6'd12, 1'b0);
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("abort_ready",   in_ready,   1'b1);
    check("abort_wb_en",   wb_en,      1'b0);
    check("abort_wb_addr", wb_addr,    '0);
    check("abort_wb_data", wb_data,    '0);
    check("abort_illegal", illegal_op, 1'b0);
    check("abort_busy",    busy,       1'b0);
    @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    check("abort_idle_busy", busy, 1'b0);
    issue(OP_ADD, 32'd40, 32'd2, 6'd13, 1'b1);
    @(negedge clk);
    check("post_abort_wb_en", wb_en, 1'b1);
`else
    for (int op = 9; op <= 11; op++) begin
      issue(4'(op), 32'd100, 32'd7, 6'd9, 1'b0);
      @(negedge clk);
      check("md_off_pulse", illegal_op, 1'b1);
      check("md_off_no_wb", wb_en, 1'b0);
      check("md_off_busy", busy, 1'b0);
      check("md_off_ready", in_ready, 1'b1);
    end
    issue(OP_ADD, 32'd40, 32'd2, 6'd13, 1'b1);
    @(negedge clk);
    check("post_md_off_wb_en", wb_en, 1'b1);
`endif

    repeat (5) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
